// File: rtl/tinv_bus_pkg.sv
// tinv_bus_pkg
// Purpose : shared types, default parameters and sizing helper for the
//           tristate-inverter bus enable controller.
// Contents: state_t (IDLE/DRIVE/TURN), *_DEF parameter defaults,
//           clog2_safe() for counter/pointer widths (never returns 0).
package tinv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int N_DRV_DEF    = 4;
  localparam int TURN_CYC_DEF = 1;
  localparam int MAX_HOLD_DEF = 8;

  // Bits needed to index n values; at least 1 so a degenerate width never
  // produces a zero-width vector.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tinv_bus_enable_ctrl_rr_pick.sv
// tinv_rr_pick
// Purpose : combinational round-robin picker. Finds the first set request
//           bit searching upward from i_ptr, wrapping N_DRV-1 -> 0.
// Ports   : i_req    [N_DRV-1:0] request vector
//           i_ptr    [PW-1:0]    highest-priority index
//           o_winner [PW-1:0]    selected index (0 when none)
//           o_valid              any request present
module tinv_rr_pick
  import tinv_bus_pkg::*;
#(
  parameter int N_DRV = N_DRV_DEF,
  localparam int PW   = clog2_safe(N_DRV)
) (
  input  logic [N_DRV-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [PW-1:0]    o_winner,
  output logic             o_valid
);

  logic [N_DRV-1:0] w_rot;
  logic [PW:0]      w_sum;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    // Rotate so bit 0 of w_rot corresponds to index i_ptr.
    w_rot    = N_DRV'({i_req, i_req} >> i_ptr);
    for (int j = 0; j < N_DRV; j++) begin
      if (w_rot[j] && !o_valid) begin
        w_sum = {1'b0, i_ptr} + (PW+1)'(j);
        // Explicit wrap: N_DRV need not be a power of two.
        if (w_sum >= (PW+1)'(N_DRV)) w_sum = w_sum - (PW+1)'(N_DRV);
        o_valid  = 1'b1;
        o_winner = w_sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/tinv_bus_enable_ctrl.sv
// tinv_bus_enable_ctrl
// Purpose : drives complementary EN/EN_BAR pairs of N_DRV tristate inverters
//           sharing one net. Round-robin arbitration, per-owner hold limit,
//           break-before-make turnaround of TURN_CYC idle cycles.
// Ports   : CLK     clock, rising edge
//           RN      synchronous active-low reset
//           req     [N_DRV-1:0] per-driver request (level)
//           gnt     [N_DRV-1:0] one-hot-or-zero grant (registered)
//           en      [N_DRV-1:0] tristate EN, equals gnt (registered)
//           en_bar  [N_DRV-1:0] tristate EN_BAR, ~en from its own flops
//           busy    high in DRIVE and TURN
//           keep_en weak bus-keeper enable, only with TINV_BUS_KEEPER_EN
// Macro   : TINV_BUS_KEEPER_EN adds the keep_en output and keeper logic.
//
// state | meaning
// IDLE  | no driver enabled, arbitrating requests
// DRIVE | one owner enabled, hold counter running
// TURN  | all drivers off for TURN_CYC cycles before next arbitration
module tinv_bus_enable_ctrl
  import tinv_bus_pkg::*;
#(
  parameter int N_DRV    = N_DRV_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [N_DRV-1:0] req,
  output logic [N_DRV-1:0] gnt,
  output logic [N_DRV-1:0] en,
  output logic [N_DRV-1:0] en_bar,
`ifdef TINV_BUS_KEEPER_EN
  output logic             keep_en,
`endif
  output logic             busy
);

  localparam int PW = clog2_safe(N_DRV);
  localparam int HW = clog2_safe(MAX_HOLD + 1);
  localparam int TW = clog2_safe(TURN_CYC + 1);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [TW-1:0]    r_turn, w_turn_nxt;
  logic [N_DRV-1:0] r_gnt, w_gnt_nxt;
  logic [N_DRV-1:0] r_en, r_en_bar;
  logic             r_busy;

  logic [PW-1:0]    w_winner;
  logic             w_valid;
  logic             w_own_req, w_other_req, w_hold_max;

  tinv_rr_pick #(.N_DRV(N_DRV)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_own_req   = |(req & r_gnt);
  assign w_other_req = |(req & ~r_gnt);
  assign w_hold_max  = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_turn_nxt  = r_turn;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt = DRIVE;
          w_gnt_nxt   = N_DRV'(1) << w_winner;
          w_hold_nxt  = HW'(1);
          w_ptr_nxt   = (w_winner == PW'(N_DRV - 1)) ? '0 : w_winner + PW'(1);
        end
      end
      DRIVE: begin
        // Owner drop and preemption collapse into one release.
        if (!w_own_req || (w_hold_max && w_other_req)) begin
          w_state_nxt = TURN;
          w_gnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_turn_nxt  = TW'(1);
        end else if ((MAX_HOLD != 0) && !w_hold_max) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      TURN: begin
        if (r_turn == TW'(TURN_CYC)) begin
          w_state_nxt = IDLE;
          w_turn_nxt  = '0;
        end else begin
          w_turn_nxt = r_turn + TW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_turn   <= '0;
      r_gnt    <= '0;
      r_en     <= '0;
      r_en_bar <= '1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_turn   <= w_turn_nxt;
      r_gnt    <= w_gnt_nxt;
      r_en     <= w_gnt_nxt;
      r_en_bar <= ~w_gnt_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign gnt    = r_gnt;
  assign en     = r_en;
  assign en_bar = r_en_bar;
  assign busy   = r_busy;

`ifdef TINV_BUS_KEEPER_EN
  logic r_keep;

  // Keeper stays off while a driver is on and for the first turnaround
  // cycle, so it never fights a strong driver that is still releasing.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_keep <= 1'b1;
    end else begin
      r_keep <= !((w_state_nxt == DRIVE) ||
                  ((w_state_nxt == TURN) && (w_turn_nxt == TW'(1))));
    end
  end

  assign keep_en = r_keep;
`endif

  a_en_onehot: assert property (@(posedge CLK) disable iff (!RN) $onehot0(r_en));
  a_en_bar:    assert property (@(posedge CLK) disable iff (!RN) r_en_bar == ~r_en);
  a_busy:      assert property (@(posedge CLK) disable iff (!RN) r_busy == (r_state != IDLE));

endmodule

// File: tb/tb_tinv_bus_enable_ctrl.sv
module tb_tinv_bus_enable_ctrl;

  logic       CLK = 1'b0;
  logic       RN, RN2;
  logic [3:0] req, req2;
  logic [3:0] gnt, en, en_bar, gnt2, en2, en_bar2;
  logic       busy, busy2;
`ifdef TINV_BUS_KEEPER_EN
  logic       keep_en, keep_en2;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;
  bit mon_on = 1'b0;
  logic [3:0] prev_en, prev_en2;

  always #5 CLK = ~CLK;

  // u_dut: TURN_CYC=1, MAX_HOLD=8. u_dut2: TURN_CYC=2, unlimited hold.
  tinv_bus_enable_ctrl #(.N_DRV(4), .TURN_CYC(1), .MAX_HOLD(8)) u_dut (
    .CLK(CLK), .RN(RN), .req(req), .gnt(gnt), .en(en), .en_bar(en_bar),
`ifdef TINV_BUS_KEEPER_EN
    .keep_en(keep_en),
`endif
    .busy(busy)
  );

  tinv_bus_enable_ctrl #(.N_DRV(4), .TURN_CYC(2), .MAX_HOLD(0)) u_dut2 (
    .CLK(CLK), .RN(RN2), .req(req2), .gnt(gnt2), .en(en2), .en_bar(en_bar2),
`ifdef TINV_BUS_KEEPER_EN
    .keep_en(keep_en2),
`endif
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Per-cycle invariants on both instances.
  always @(negedge CLK) begin
    if (mon_on) begin
      if (!$onehot0(en) || (en_bar !== ~en) || (gnt !== en)) viol++;
      if (en != 4'd0 && prev_en != 4'd0 && en != prev_en) viol++;
      if (!$onehot0(en2) || (en_bar2 !== ~en2) || (gnt2 !== en2)) viol++;
      if (en2 != 4'd0 && prev_en2 != 4'd0 && en2 != prev_en2) viol++;
    end
    prev_en  = en;
    prev_en2 = en2;
  end

  initial begin
    logic [31:0] exp_en;
    RN = 1'b0; RN2 = 1'b0; req = '0; req2 = '0;
    repeat (2) tick();
    mon_on = 1'b1;

    // Reset state
    chk("rst_en", en, 4'h0);
    chk("rst_en_bar", en_bar, 4'hF);
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", u_dut.r_ptr, 0);
`ifdef TINV_BUS_KEEPER_EN
    chk("rst_keep", keep_en, 1'b1);
`endif

    // First grant, one cycle latency
    RN = 1'b1; req = 4'b0101;
    tick();
    chk("first_en", en, 4'b0001);
    chk("first_en_bar", en_bar, 4'b1110);
    chk("first_gnt", gnt, 4'b0001);
    chk("first_busy", busy, 1'b1);
    chk("first_ptr", u_dut.r_ptr, 1);
`ifdef TINV_BUS_KEEPER_EN
    chk("first_keep", keep_en, 1'b0);
`endif

    // Round robin with hold limit 8, turnaround 2 cycles of en=0
    RN = 1'b0; tick();
    RN = 1'b1; req = 4'b1111;
    for (int t = 1; t <= 50; t++) begin
      tick();
      exp_en = (((t - 1) % 10) < 8) ? (32'd1 << (((t - 1) / 10) % 4)) : 32'd0;
      chk("rr_seq", en, exp_en);
    end

    // Single requester never preempted
    RN = 1'b0; tick();
    RN = 1'b1; req = 4'b1000;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("solo", en, 4'b1000);
    end

    // Reset in the middle of DRIVE
    RN = 1'b0; tick();
    chk("mid_rst_en", en, 4'h0);
    chk("mid_rst_en_bar", en_bar, 4'hF);
    chk("mid_rst_busy", busy, 1'b0);
    RN = 1'b1; req = 4'b0010;
    tick();
    chk("post_rst_en", en, 4'b0010);
    chk("post_rst_busy", busy, 1'b1);

    // Owner drop with TURN_CYC=2 on the second instance
    RN2 = 1'b1; req2 = 4'b0101;
    tick();
    chk("t2_grant0", en2, 4'b0001);
    req2 = 4'b0100;
    tick();
    chk("t2_turn1_en", en2, 4'h0);
    chk("t2_turn1_busy", busy2, 1'b1);
`ifdef TINV_BUS_KEEPER_EN
    chk("t2_turn1_keep", keep_en2, 1'b0);
`endif
    tick();
    chk("t2_turn2_en", en2, 4'h0);
    chk("t2_turn2_busy", busy2, 1'b1);
`ifdef TINV_BUS_KEEPER_EN
    chk("t2_turn2_keep", keep_en2, 1'b1);
`endif
    tick();
    chk("t2_idle_en", en2, 4'h0);
    chk("t2_idle_busy", busy2, 1'b0);
`ifdef TINV_BUS_KEEPER_EN
    chk("t2_idle_keep", keep_en2, 1'b1);
`endif
    tick();
    chk("t2_grant2", en2, 4'b0100);
    chk("t2_grant2_bar", en_bar2, 4'b1011);
`ifdef TINV_BUS_KEEPER_EN
    chk("t2_drive_keep", keep_en2, 1'b0);
`endif

    // Unlimited hold: owner 2 keeps the bus despite competitors
    req2 = 4'b0111;
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk("nolimit", en2, 4'b0100);
    end

    // Owner drops; pointer at 3 wraps to 0 as next winner
    req2 = 4'b0011;
    repeat (3) tick();
    chk("wrap_gap", en2, 4'h0);
    tick();
    chk("wrap_pick", en2, 4'b0001);

    tick();
    mon_on = 1'b0;
    chk("invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
